// File: rtl/encoder_4x2.sv
// encoder_4x2: registered 4-to-2 priority encoder with valid and multi-hot error flags.
// The highest active request wins (d4 > d3 > d2 > d1). All outputs have one cycle of latency.
// Optional feature: define ENCODER_4X2_ERRCNT_EN to add err_cnt.
// err_cnt is an 8-bit saturating count of the multi-hot samples.
module encoder_4x2 #(
  parameter bit HOLD_ON_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       d4,
  output logic       x,
  output logic       y,
  output logic       valid,
  output logic       err
`ifdef ENCODER_4X2_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int unsigned CODE_W = 2;
  localparam int unsigned CNT_W  = 8;

  logic [CODE_W-1:0] w_code;
  logic              w_any;
  logic              w_multi;
  logic [CODE_W-1:0] r_code;
  logic              r_valid;
  logic              r_err;

  // Encode the winning request by priority and flag the idle and multi-hot cases.
  always_comb begin
    w_code  = 2'b00;
    w_any   = d1 | d2 | d3 | d4;
    w_multi = (d1 & d2) | (d1 & d3) | (d1 & d4) |
              (d2 & d3) | (d2 & d4) | (d3 & d4);
    if (d4)      w_code = 2'b11;
    else if (d3) w_code = 2'b10;
    else if (d2) w_code = 2'b01;
    else         w_code = 2'b00;
  end

  // Output registers. When idle, the code is either held or cleared to 00.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code  <= 2'b00;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_any;
      r_err   <= w_multi;
      if (w_any) begin
        r_code <= w_code;
      end else if (!HOLD_ON_IDLE) begin
        r_code <= 2'b00;
      end
    end
  end

  assign x     = r_code[1];
  assign y     = r_code[0];
  assign valid = r_valid;
  assign err   = r_err;

`ifdef ENCODER_4X2_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Saturating count of multi-hot samples. It updates on the same edge that sets err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_multi && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_encoder_4x2.sv
// tb_encoder_4x2: runs a table of directed vectors, then a random run checked against a behavioural model.
// It drives two instances in parallel, one with HOLD_ON_IDLE=1 and one with HOLD_ON_IDLE=0.
module tb_encoder_4x2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d1 = 1'b0, d2 = 1'b0, d3 = 1'b0, d4 = 1'b0;
  logic x_h, y_h, v_h, e_h;
  logic x_n, y_n, v_n, e_n;
`ifdef ENCODER_4X2_ERRCNT_EN
  logic [7:0] c_h, c_n;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [1:0] m_hold   = 2'b00;
  logic [1:0] m_nohold = 2'b00;
  logic       m_valid  = 1'b0;
  logic       m_err    = 1'b0;
  int         m_cnt    = 0;

  always #5 clk = ~clk;

  encoder_4x2 #(.HOLD_ON_IDLE(1'b1)) dut_h (
    .clk(clk), .rst(rst), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .x(x_h), .y(y_h), .valid(v_h), .err(e_h)
`ifdef ENCODER_4X2_ERRCNT_EN
    , .err_cnt(c_h)
`endif
  );

  encoder_4x2 #(.HOLD_ON_IDLE(1'b0)) dut_n (
    .clk(clk), .rst(rst), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .x(x_n), .y(y_n), .valid(v_n), .err(e_n)
`ifdef ENCODER_4X2_ERRCNT_EN
    , .err_cnt(c_n)
`endif
  );

  typedef struct {
    logic       r;
    logic [3:0] d;   // {d4,d3,d2,d1}
    logic [1:0] ch;  // expected code, hold instance
    logic [1:0] cn;  // expected code, no-hold instance
    logic       v;
    logic       e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance the model on one sampled edge: the highest active line wins, and more than one line flags err.
  task automatic model_step(input logic r, input logic [3:0] d);
    int n;
    int code;
    n = $countones(d);
    if (r) begin
      m_hold = 2'b00; m_nohold = 2'b00; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else if (n == 0) begin
      m_nohold = 2'b00; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      code = 0;
      for (int i = 0; i < 4; i++) if (d[i]) code = i;
      m_hold   = 2'(code);
      m_nohold = 2'(code);
      m_valid  = 1'b1;
      m_err    = (n > 1);
      if (n > 1 && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  endtask

  // Drive inputs on the falling edge, update the model at the rising edge, then settle before sampling.
  task automatic drive(input logic r, input logic [3:0] d);
    @(negedge clk);
    rst = r;
    {d4, d3, d2, d1} = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_code_h"}, 32'({x_h, y_h}), 32'(m_hold));
    chk({tag, "_code_n"}, 32'({x_n, y_n}), 32'(m_nohold));
    chk({tag, "_valid"},  32'({v_h, v_n}), 32'({m_valid, m_valid}));
    chk({tag, "_err"},    32'({e_h, e_n}), 32'({m_err, m_err}));
`ifdef ENCODER_4X2_ERRCNT_EN
    chk({tag, "_cnt_h"}, 32'(c_h), 32'(m_cnt));
    chk({tag, "_cnt_n"}, 32'(c_n), 32'(m_cnt));
`endif
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b1, 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0}; // reset dominates d4
    tbl[1]  = '{1'b1, 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0001, 2'b00, 2'b00, 1'b1, 1'b0}; // d1
    tbl[3]  = '{1'b0, 4'b0010, 2'b01, 2'b01, 1'b1, 1'b0}; // d2
    tbl[4]  = '{1'b0, 4'b0100, 2'b10, 2'b10, 1'b1, 1'b0}; // d3
    tbl[5]  = '{1'b0, 4'b1000, 2'b11, 2'b11, 1'b1, 1'b0}; // d4
    tbl[6]  = '{1'b0, 4'b0011, 2'b01, 2'b01, 1'b1, 1'b1}; // d1+d2
    tbl[7]  = '{1'b0, 4'b1111, 2'b11, 2'b11, 1'b1, 1'b1}; // all
    tbl[8]  = '{1'b0, 4'b0100, 2'b10, 2'b10, 1'b1, 1'b0}; // d3, err clears
    tbl[9]  = '{1'b0, 4'b0000, 2'b10, 2'b00, 1'b0, 1'b0}; // idle
    tbl[10] = '{1'b0, 4'b0000, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'b1000, 2'b11, 2'b11, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0}; // mid-operation reset
    tbl[13] = '{1'b0, 4'b1000, 2'b11, 2'b11, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'b0110, 2'b10, 2'b10, 1'b1, 1'b1}; // d2+d3
    tbl[15] = '{1'b1, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0}; // idle after reset keeps 00

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d_code_h", i), 32'({x_h, y_h}), 32'(tbl[i].ch));
      chk($sformatf("vec%0d_code_n", i), 32'({x_n, y_n}), 32'(tbl[i].cn));
      chk($sformatf("vec%0d_valid", i),  32'({v_h, v_n}), 32'({tbl[i].v, tbl[i].v}));
      chk($sformatf("vec%0d_err", i),    32'({e_h, e_n}), 32'({tbl[i].e, tbl[i].e}));
`ifdef ENCODER_4X2_ERRCNT_EN
      chk($sformatf("vec%0d_cnt", i), 32'(c_h), 32'(m_cnt));
`endif
    end

    // Random run against the model.
    for (int i = 0; i < 300; i++) begin
      logic       r;
      logic [3:0] d;
      r = (($urandom % 16) == 0);
      d = 4'($urandom % 16);
      drive(r, d);
      check_model($sformatf("rnd%0d", i));
    end

`ifdef ENCODER_4X2_ERRCNT_EN
    // Counter saturation: 300 multi-hot samples must stop at 255, then reset clears it.
    drive(1'b1, 4'b0000);
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 4'b1111);
      if (i == 0)   chk("sat_first", 32'(c_h), 32'd1);
      if (i == 254) chk("sat_reach", 32'(c_h), 32'd255);
    end
    chk("sat_hold_h", 32'(c_h), 32'd255);
    chk("sat_hold_n", 32'(c_n), 32'd255);
    drive(1'b1, 4'b1111);
    chk("sat_clear", 32'({c_h, c_n}), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
